// File: rtl/mem_pkg.sv
// Shared types and constants for the 8-entry register memory and its arbiter.
// Pure declarations; no logic.
package mem_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        CLEAR = 2'd2
    } state_e;

    localparam int MEM_DEPTH  = 8;
    localparam int ENTRY_BITS = 3;
    localparam logic [ENTRY_BITS-1:0] LAST_ENTRY = ENTRY_BITS'(MEM_DEPTH - 1);
endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the memory arbiter: request/command in, acknowledge/read data out.
// The requester holds req and its command stable until ack; there is no other backpressure.
interface mem_arbiter_if #(
    parameter int WIDTH = 32
) ();
    logic                            req;
    logic                            we;
    logic [mem_pkg::ENTRY_BITS-1:0]  addr;
    logic [WIDTH-1:0]                wdata;
    logic                            ack;
    logic [WIDTH-1:0]                rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/memory.sv
// 8-entry register memory: combinational read of the addressed entry, write on the rising edge.
// Single port; callers must serialise their accesses.
module memory
    import mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      idata,
    output logic [WIDTH-1:0]      odata
);
    logic [WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [WIDTH-1:0] mem_d [MEM_DEPTH];
    logic [ENTRY_BITS-1:0] idx;
    logic unused_addr_hi;

    // Only the low bits select an entry; the rest of the bus is always zero.
    assign idx            = addr[ENTRY_BITS-1:0];
    assign unused_addr_hi = ^addr[ADDR_WIDTH-1:ENTRY_BITS];
    assign odata          = mem_q[idx];

    always_comb begin
        mem_d = mem_q;
        if (write) begin
            mem_d[idx] = idata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end
endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; grant is combinational from req, `last` updates on upd.
// A sole requester always wins; on a tie the port that was not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic       gnt_id,
    output logic       gnt_vld
);
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_vld = |req;
        gnt_id  = (req == 2'b11) ? ~last_q : req[1];
        last_d  = upd ? gnt_id : last_q;
    end

    // Reset to port 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two requesters (ack one cycle after an IDLE sample) and sweeps it to zero on clr_start.
// One access per 2 cycles; requests wait while a clear or the other port is being served.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_arbiter_if.slave          p0,
    mem_arbiter_if.slave          p1,
    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_idata,
    input  logic [WIDTH-1:0]      mem_odata
);
    state_e                state_q, state_d;
    logic [ENTRY_BITS-1:0] cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [ENTRY_BITS-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  done_q, done_d;
    logic                  arb_upd;
    logic                  gnt_id;
    logic                  gnt_vld;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({p1.req, p0.req}),
        .upd     (arb_upd),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld)
    );

    // The memory-side registers double as the request latches for SERVE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done_d  = 1'b0;
        arb_upd = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                end else if (gnt_vld) begin
                    state_d = SERVE;
                    arb_upd = 1'b1;
                    ack0_d  = ~gnt_id;
                    ack1_d  = gnt_id;
                    wr_d    = gnt_id ? p1.we    : p0.we;
                    addr_d  = gnt_id ? p1.addr  : p0.addr;
                    wdata_d = gnt_id ? p1.wdata : p0.wdata;
                end
            end
            SERVE: begin
                state_d = IDLE;
            end
            CLEAR: begin
                if (cnt_q == LAST_ENTRY) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wr_d   = 1'b1;
                    addr_d = cnt_d;
                    done_d = (cnt_d == LAST_ENTRY);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign clr_done  = done_q;
    assign mem_write = wr_q;
    assign mem_addr  = ADDR_WIDTH'(addr_q);
    assign mem_idata = wdata_q;

    // Read data is the only combinational path: the memory read of the latched address.
    assign p0.ack   = ack0_q;
    assign p1.ack   = ack1_q;
    assign p0.rdata = ack0_q ? mem_odata : '0;
    assign p1.rdata = ack1_q ? mem_odata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter with a real memory: cycle table, directed corner sequences, random traffic vs. a transaction model.
module tb_mem_arbiter;
    localparam int W  = 32;
    localparam int AW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_idata;
    logic [W-1:0]  mem_odata;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter_if #(.WIDTH(W)) p0_if ();
    mem_arbiter_if #(.WIDTH(W)) p1_if ();

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if), .clr_start(clr_start),
        .busy(busy), .clr_done(clr_done), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_idata(mem_idata), .mem_odata(mem_odata)
    );

    memory #(.WIDTH(W), .ADDR_WIDTH(AW)) u_mem (
        .clk(clk), .rst(rst), .write(mem_write), .addr(mem_addr),
        .idata(mem_idata), .odata(mem_odata)
    );

    typedef struct packed {
        logic r0; logic w0; logic [2:0] a0; logic [31:0] d0;
        logic r1; logic w1; logic [2:0] a1; logic [31:0] d1;
        logic clr;
    } stim_t;

    typedef struct packed {
        logic ack0; logic ack1; logic [31:0] rd0; logic [31:0] rd1;
        logic mw; logic [2:0] ma; logic [31:0] mi; logic bsy; logic dn;
    } resp_t;

    typedef struct { stim_t s; resp_t e; } vec_t;

    vec_t tbl[$];

    function automatic stim_t st(input logic r0, input logic w0, input logic [2:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [2:0] a1, input logic [31:0] d1,
                                 input logic clr);
        stim_t s;
        s.r0 = r0; s.w0 = w0; s.a0 = a0; s.d0 = d0;
        s.r1 = r1; s.w1 = w1; s.a1 = a1; s.d1 = d1;
        s.clr = clr;
        return s;
    endfunction

    function automatic resp_t ex(input logic k0, input logic k1, input logic [31:0] rd0, input logic [31:0] rd1,
                                 input logic mw, input logic [2:0] ma, input logic [31:0] mi,
                                 input logic bsy, input logic dn);
        resp_t e;
        e.ack0 = k0; e.ack1 = k1; e.rd0 = rd0; e.rd1 = rd1;
        e.mw = mw; e.ma = ma; e.mi = mi; e.bsy = bsy; e.dn = dn;
        return e;
    endfunction

    task automatic add(input stim_t s, input resp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [2:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
        end else begin
            p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
        end
    endtask

    task automatic apply(input stim_t s);
        drive(0, s.r0, s.w0, s.a0, s.d0);
        drive(1, s.r1, s.w1, s.a1, s.d1);
        clr_start = s.clr;
    endtask

    task automatic check_resp(input string tag, input resp_t e);
        chk({tag, ".ack0"}, p0_if.ack, e.ack0);
        chk({tag, ".ack1"}, p1_if.ack, e.ack1);
        chk({tag, ".rdata0"}, p0_if.rdata, e.rd0);
        chk({tag, ".rdata1"}, p1_if.rdata, e.rd1);
        chk({tag, ".mem_write"}, mem_write, e.mw);
        chk({tag, ".mem_addr"}, mem_addr, e.ma);
        chk({tag, ".mem_idata"}, mem_idata, e.mi);
        chk({tag, ".busy"}, busy, e.bsy);
        chk({tag, ".clr_done"}, clr_done, e.dn);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        apply('0);
        repeat (2) @(posedge clk);
        #1;
        check_resp("reset", '0);
        rst = 1'b1;
    endtask

    // Single access on one port against an otherwise idle arbiter: ack must follow the sampling edge.
    task automatic access(input int p, input logic w, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] rd);
        int   n;
        logic got;
        n   = 0;
        got = 1'b0;
        rd  = '0;
        drive(p, 1'b1, w, a, d);
        while (!got && n < 12) begin
            tick();
            n++;
            got = (p == 0) ? p0_if.ack : p1_if.ack;
        end
        chk("access.latency", n, 1);
        if (got) rd = (p == 0) ? p0_if.rdata : p1_if.rdata;
        drive(p, 1'b0, 1'b0, 3'd0, 32'd0);
        tick();
    endtask

    // Random-traffic model state
    logic [31:0]   mdl [8];
    bit            pend [2];
    int            start_t [2];
    logic          rw [2];
    logic [2:0]    ra [2];
    logic [31:0]   rwd [2];
    int            last_srv;
    logic          hmw [8];
    logic [AW-1:0] hma [8];
    logic [31:0]   hmi [8];
    logic          hack [8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          rem0, rem1, nack, last_k, bad;
        logic [1:0]  ak;
        logic [31:0] rdv;

        // ---------- cycle table: contention, single accesses, ignored clear, clear with pending req1 ----------
        add(st(1,1,1,32'h11, 1,1,2,32'h22, 0), '0);
        add(st(1,1,1,32'h11, 1,1,2,32'h22, 0), ex(1,0,0,0, 1,1,32'h11, 1,0));
        add(st(0,0,0,0,      1,1,2,32'h22, 0), '0);
        add(st(0,0,0,0,      1,1,2,32'h22, 0), ex(0,1,0,0, 1,2,32'h22, 1,0));
        add(st(1,0,1,0,      0,0,0,0,      0), '0);
        add(st(0,0,0,0,      1,0,2,0,      0), ex(1,0,32'h11,0, 0,1,0, 1,0));
        add(st(0,0,0,0,      1,0,2,0,      0), '0);
        add(st(1,1,3,32'hDEADBEEF, 0,0,0,0, 0), ex(0,1,0,32'h22, 0,2,0, 1,0));
        add(st(1,1,3,32'hDEADBEEF, 0,0,0,0, 0), '0);
        add(st(1,0,3,0,      0,0,0,0,      0), ex(1,0,0,0, 1,3,32'hDEADBEEF, 1,0));
        add(st(1,0,3,0,      0,0,0,0,      0), '0);
        add(st(0,0,0,0,      0,0,0,0,      0), ex(1,0,32'hDEADBEEF,0, 0,3,0, 1,0));
        add(st(1,0,1,0,      0,0,0,0,      0), '0);
        add(st(0,0,0,0,      0,0,0,0,      1), ex(1,0,32'h11,0, 0,1,0, 1,0));
        add(st(0,0,0,0,      0,0,0,0,      0), '0);
        add(st(0,0,0,0,      0,0,0,0,      0), '0);
        add(st(0,0,0,0,      1,0,2,0,      1), '0);
        for (int k = 0; k < 8; k++) begin
            add(st(0,0,0,0, 1,0,2,0, 0), ex(0,0,0,0, 1,3'(k),0, 1,(k == 7)));
        end
        add(st(0,0,0,0,      1,0,2,0,      0), '0);
        add(st(0,0,0,0,      0,0,0,0,      0), ex(0,1,0,0, 0,2,0, 1,0));
        add(st(0,0,0,0,      0,0,0,0,      0), '0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            check_resp($sformatf("tbl[%0d]", i), tbl[i].e);
            apply(tbl[i].s);
            tick();
        end

        // ---------- fairness: both ports hold req for 8 accesses each ----------
        do_reset();
        drive(0, 1'b1, 1'b0, 3'd0, 32'd0);
        drive(1, 1'b1, 1'b0, 3'd1, 32'd0);
        rem0 = 8; rem1 = 8; nack = 0; last_k = -1;
        for (int k = 0; k < 60 && (rem0 > 0 || rem1 > 0); k++) begin
            tick();
            if (p0_if.ack || p1_if.ack) begin
                chk("fair.exclusive", p0_if.ack & p1_if.ack, 0);
                chk("fair.order", p1_if.ack, 32'(nack % 2));
                if (last_k >= 0) chk("fair.gap", k - last_k, 2);
                last_k = k;
                nack++;
                if (p0_if.ack && rem0 > 0) begin rem0--; if (rem0 == 0) p0_if.req = 1'b0; end
                if (p1_if.ack && rem1 > 0) begin rem1--; if (rem1 == 0) p1_if.req = 1'b0; end
            end
        end
        chk("fair.count", nack, 16);
        tick();

        // ---------- full fill, clear sweep, read-back of every entry ----------
        do_reset();
        for (int i = 0; i < 8; i++) access(0, 1'b1, 3'(i), 32'hA5A5A5A0 + i, rd);
        for (int i = 0; i < 8; i++) begin
            access(1, 1'b0, 3'(i), 32'd0, rd);
            chk($sformatf("fill.rd[%0d]", i), rd, 32'hA5A5A5A0 + i);
        end
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_resp($sformatf("sweep[%0d]", k), ex(0,0,0,0, 1,3'(k),0, 1,(k == 7)));
            tick();
        end
        chk("sweep.end.busy", busy, 0);
        chk("sweep.end.done", clr_done, 0);
        for (int i = 0; i < 8; i++) begin
            access(0, 1'b0, 3'(i), 32'd0, rd);
            chk($sformatf("cleared.rd[%0d]", i), rd, 0);
        end

        // ---------- reset in the middle of a sweep ----------
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (4) tick();
        chk("midclr.addr", mem_addr, 4);
        chk("midclr.write", mem_write, 1);
        rst = 1'b0;
        #1;
        chk("midclr.rst.write", mem_write, 0);
        chk("midclr.rst.busy", busy, 0);
        chk("midclr.rst.addr", mem_addr, 0);
        chk("midclr.rst.done", clr_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 3'd5, 32'd0);
        drive(1, 1'b1, 1'b0, 3'd6, 32'd0);
        tick();
        chk("midclr.tie.ack0", p0_if.ack, 1);
        chk("midclr.tie.ack1", p1_if.ack, 0);
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0);
        tick();

        // ---------- random traffic against a transaction-level model ----------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mdl[i] = '0; hmw[i] = 1'b0; hma[i] = '0; hmi[i] = '0; hack[i] = 1'b0;
        end
        pend[0] = 0; pend[1] = 0;
        start_t[0] = 0; start_t[1] = 0;
        last_srv = 1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int k = 0; k < 7; k++) begin
                hmw[k] = hmw[k+1]; hma[k] = hma[k+1]; hmi[k] = hmi[k+1]; hack[k] = hack[k+1];
            end
            ak = {p1_if.ack, p0_if.ack};
            hmw[7] = mem_write; hma[7] = mem_addr; hmi[7] = mem_idata; hack[7] = |ak;
            if (|ak) chk("rnd.exclusive", ak[0] & ak[1], 0);
            if (!(|ak) && mem_write) chk("rnd.clear_idata", mem_idata, 0);
            for (int p = 0; p < 2; p++) begin
                int q;
                q   = 1 - p;
                rdv = (p == 0) ? p0_if.rdata : p1_if.rdata;
                if (!ak[p]) begin
                    if (!busy) chk($sformatf("rnd.idle_rdata%0d", p), rdv, 0);
                end else begin
                    chk($sformatf("rnd.ack%0d_pending", p), pend[p], 1);
                    if (pend[p]) begin
                        chk("rnd.fair", (pend[q] && start_t[q] < t && last_srv == p), 0);
                        chk("rnd.rdata", rdv, mdl[ra[p]]);
                        chk("rnd.mem_write", mem_write, rw[p]);
                        chk("rnd.mem_addr", mem_addr, ra[p]);
                        chk("rnd.mem_idata", mem_idata, rwd[p]);
                        if (rw[p]) mdl[ra[p]] = rwd[p];
                        last_srv = p;
                        pend[p]  = 0;
                    end
                end
            end
            if (clr_done) begin
                bad = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!hmw[k] || hma[k] != AW'(k) || hmi[k] != 0 || hack[k]) bad++;
                end
                chk("rnd.sweep", bad, 0);
                for (int i = 0; i < 8; i++) mdl[i] = '0;
            end
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && t - start_t[p] > 30) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rnd.timeout port%0d: waited %0d cycles, limit 30", p, t - start_t[p]);
                    pend[p] = 0;
                end
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p]    = 1;
                    start_t[p] = t;
                    rw[p]      = 1'($urandom_range(0, 1));
                    ra[p]      = 3'($urandom_range(0, 7));
                    rwd[p]     = $urandom;
                end
                drive(p, pend[p], rw[p], ra[p], rwd[p]);
            end
            clr_start = ($urandom_range(0, 49) == 0)
                        && !(pend[0] && t - start_t[0] > 4)
                        && !(pend[1] && t - start_t[1] > 4);
        end
        apply('0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
